sum_display_scanner: RTL and testbench



---
 rtl/sum_display_scanner.sv | 139 +++++++++++++
 tb/tb_sum_display_scanner.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/sum_display_scanner.sv
// rtl/sum_display_scanner.sv - 5-bit sum to BCD converter with multiplexed 7-segment scanner
module sum_display_scanner #(
  parameter int REFRESH_DIV = 50000
) (
  input  logic       mclk,
  input  logic       rs,
  input  logic [4:0] sum_in,
  input  logic       sum_valid,
  output logic       ready,
  output logic [7:0] seg,
  output logic [3:0] anode
);

  localparam int PW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(REFRESH_DIV - 1);

  typedef enum logic [1:0] {IDLE, CONV, COMMIT} state_t;

  state_t        state_q, state_d;
  logic [4:0]    bin_q, bin_d;
  logic [5:0]    bcd_q, bcd_d;
  logic [2:0]    step_q, step_d;
  logic [1:0]    tens_q, tens_d;
  logic [3:0]    ones_q, ones_d;
  logic [PW-1:0] presc_q, presc_d;
  logic [1:0]    idx_q, idx_d;
  logic [7:0]    seg_q, seg_d;
  logic [3:0]    anode_q, anode_d;
  logic [3:0]    ones_adj;

  function automatic logic [7:0] seg_of(input logic [3:0] d);
    case (d)
      4'd0:    seg_of = 8'hC0;
      4'd1:    seg_of = 8'hF9;
      4'd2:    seg_of = 8'hA4;
      4'd3:    seg_of = 8'hB0;
      4'd4:    seg_of = 8'h99;
      4'd5:    seg_of = 8'h92;
      4'd6:    seg_of = 8'h82;
      4'd7:    seg_of = 8'hF8;
      4'd8:    seg_of = 8'h80;
      4'd9:    seg_of = 8'h90;
      default: seg_of = 8'hFF;
    endcase
  endfunction

  // State register plus all datapath and scanner flops; rs overrides everything
  always_ff @(posedge mclk) begin
    if (rs) begin
      state_q <= IDLE;
      bin_q   <= '0;
      bcd_q   <= '0;
      step_q  <= '0;
      tens_q  <= '0;
      ones_q  <= '0;
      presc_q <= '0;
      idx_q   <= '0;
      seg_q   <= 8'hFF;
      anode_q <= 4'hF;
    end else begin
      state_q <= state_d;
      bin_q   <= bin_d;
      bcd_q   <= bcd_d;
      step_q  <= step_d;
      tens_q  <= tens_d;
      ones_q  <= ones_d;
      presc_q <= presc_d;
      idx_q   <= idx_d;
      seg_q   <= seg_d;
      anode_q <= anode_d;
    end
  end

  // Next-state logic: accept in IDLE, five shift steps in CONV, one COMMIT edge
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (sum_valid) state_d = CONV;
      CONV:    if (step_q == 3'd4) state_d = COMMIT;
      COMMIT:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output logic: the block only listens while idle
  always_comb begin
    ready = (state_q == IDLE);
  end

  // Double-dabble datapath; the tens field never exceeds 3, so only ones needs the +3 fixup
  always_comb begin
    bin_d    = bin_q;
    bcd_d    = bcd_q;
    step_d   = step_q;
    tens_d   = tens_q;
    ones_d   = ones_q;
    ones_adj = (bcd_q[3:0] >= 4'd5) ? bcd_q[3:0] + 4'd3 : bcd_q[3:0];
    case (state_q)
      IDLE: begin
        if (sum_valid) begin
          bin_d  = sum_in;
          bcd_d  = '0;
          step_d = '0;
        end
      end
      CONV: begin
        bcd_d  = {bcd_q[4], ones_adj, bin_q[4]};
        bin_d  = {bin_q[3:0], 1'b0};
        step_d = step_q + 3'd1;
      end
      COMMIT: begin
        tens_d = bcd_q[5:4];
        ones_d = bcd_q[3:0];
      end
      default: ;
    endcase
  end

  // Free-running scanner; seg and anode both derive from the current index so they stay paired
  always_comb begin
    if (presc_q == PRESC_LAST) begin
      presc_d = '0;
      idx_d   = idx_q + 2'd1;
    end else begin
      presc_d = presc_q + 1'b1;
      idx_d   = idx_q;
    end
    anode_d = ~(4'b0001 << idx_q);
    case (idx_q)
      2'd0:    seg_d = seg_of(ones_q);
      2'd1:    seg_d = (tens_q == 2'd0) ? 8'hFF : seg_of({2'b00, tens_q});
      default: seg_d = 8'hFF;
    endcase
  end

  assign seg   = seg_q;
  assign anode = anode_q;

endmodule

// File: tb/tb_sum_display_scanner.sv
// tb/tb_sum_display_scanner.sv - scoreboard bench for sum_display_scanner at two refresh rates
module tb_sum_display_scanner;

  logic       mclk = 1'b0;
  logic       rs = 1'b1;
  logic       sum_valid = 1'b0;
  logic [4:0] sum_in = 5'd0;
  logic       ready_a, ready_b;
  logic [7:0] seg_a, seg_b;
  logic [3:0] anode_a, anode_b;

  always #5 mclk = ~mclk;

  sum_display_scanner #(.REFRESH_DIV(4)) dut_a (
    .mclk(mclk), .rs(rs), .sum_in(sum_in), .sum_valid(sum_valid),
    .ready(ready_a), .seg(seg_a), .anode(anode_a)
  );

  sum_display_scanner #(.REFRESH_DIV(1)) dut_b (
    .mclk(mclk), .rs(rs), .sum_in(sum_in), .sum_valid(sum_valid),
    .ready(ready_b), .seg(seg_b), .anode(anode_b)
  );

  int checks = 0;
  int failures = 0;
  int q[$];

  function automatic logic [7:0] digit_seg(input int d);
    logic [7:0] tab [10];
    tab = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8, 8'h80, 8'h90};
    return tab[d];
  endfunction

  function automatic int exp_seg(input int v, input int idx);
    if (idx == 0) return int'(digit_seg(v % 10));
    if (idx == 1) return (v / 10 == 0) ? 32'hFF : int'(digit_seg(v / 10));
    return 32'hFF;
  endfunction

  function automatic int exp_anode(input int idx);
    case (idx)
      0:       return 32'hE;
      1:       return 32'hD;
      2:       return 32'hB;
      default: return 32'h7;
    endcase
  endfunction

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: rs as seen on the last edge, shown value, busy-length tracking
  logic rs_e;
  always @(posedge mclk) rs_e <= rs;

  int  ncyc = 0;
  int  low = 0;
  int  disp = 0;
  bit  seen_reset = 1'b0;

  always @(negedge mclk) begin
    int ia, ib;
    if (rs_e === 1'b1) begin
      check("rst_ready", int'(ready_a), 1);
      check("rst_seg_a", int'(seg_a), 32'hFF);
      check("rst_anode_a", int'(anode_a), 32'hF);
      check("rst_seg_b", int'(seg_b), 32'hFF);
      check("rst_anode_b", int'(anode_b), 32'hF);
      q.delete();
      disp = 0;
      ncyc = 0;
      low = 0;
      seen_reset = 1'b1;
    end else if (seen_reset) begin
      ncyc++;
      ia = ((ncyc - 1) / 4) % 4;
      ib = (ncyc - 1) % 4;
      check("anode_a", int'(anode_a), exp_anode(ia));
      check("seg_a", int'(seg_a), exp_seg(disp, ia));
      check("anode_b", int'(anode_b), exp_anode(ib));
      check("seg_b", int'(seg_b), exp_seg(disp, ib));
      if (!ready_a) begin
        low++;
      end else if (low > 0) begin
        check("busy_cycles", low, 6);
        check("sb_nonempty", int'(q.size() != 0), 1);
        if (q.size() != 0) disp = q.pop_front();
        low = 0;
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) @(negedge mclk);
  endtask

  task automatic send(input int v);
    int n = 0;
    @(negedge mclk);
    while (!ready_a && n < 50) begin
      @(negedge mclk);
      n++;
    end
    if (!ready_a) begin
      checks++;
      failures++;
      $display("FAIL send_timeout actual=ready0 required=ready1 value=%0d", v);
      return;
    end
    sum_in = 5'(v);
    sum_valid = 1'b1;
    q.push_back(v);
    @(negedge mclk);
    sum_valid = 1'b0;
    sum_in = 5'($urandom);
  endtask

  initial begin
    int dir[5];
    int n;
    dir = '{19, 31, 7, 10, 0};
    rs = 1'b1;
    repeat (3) @(negedge mclk);
    rs = 1'b0;
    idle(24);

    foreach (dir[i]) begin
      send(dir[i]);
      idle(24);
    end

    // 12 accepted, 5 held valid through the busy window and taken once ready returns
    send(12);
    sum_in = 5'd5;
    sum_valid = 1'b1;
    n = 0;
    while (!ready_a && n < 50) begin
      @(negedge mclk);
      n++;
    end
    q.push_back(5);
    @(negedge mclk);
    sum_valid = 1'b0;
    idle(24);

    // Reset in the middle of a conversion, then a clean retry
    send(25);
    idle(2);
    rs = 1'b1;
    @(negedge mclk);
    rs = 1'b0;
    idle(3);
    send(25);
    idle(24);

    repeat (40) begin
      send(int'($urandom_range(0, 31)));
      idle(int'($urandom_range(0, 20)));
    end

    n = 0;
    while (q.size() > 0 && n < 100) begin
      @(negedge mclk);
      n++;
    end
    idle(20);
    check("sb_drained", q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
